// File: rtl/edf_queue_arbiter_pkg.sv
// Shared constants and types for the EDF queue arbiter.
// Optional round-robin tie breaking is enabled with EDF_TIE_ROUND_ROBIN_EN.
package edf_pkg;
    localparam int DEFAULT_NUMBER_OF_QUEUES = 4;
    localparam int DEFAULT_REGISTER_SIZE    = 32;
    localparam int ID_WIDTH                 = $clog2(DEFAULT_NUMBER_OF_QUEUES);

    typedef logic [DEFAULT_REGISTER_SIZE-1:0] deadline_t;

    // Remaining-deadline value of a non-periodic queue: least urgent, still eligible.
    localparam deadline_t DEADLINE_DISABLED = '1;
endpackage

// File: rtl/edf_queue_arbiter_if.sv
// Grant handshake between the EDF arbiter (master) and the queueing domain (slave).
// valid_and_ready is a one-cycle pulse; the queue named by id is popped in that cycle.
interface edf_queue_arbiter_if
    import edf_pkg::*;
#(
    parameter int NUMBER_OF_QUEUES = DEFAULT_NUMBER_OF_QUEUES
) ();
    localparam int ID_W = $clog2(NUMBER_OF_QUEUES);

    logic [NUMBER_OF_QUEUES-1:0] empty;
    logic                        ready;
    logic [ID_W-1:0]             id;
    logic                        valid_and_ready;

    modport master (
        input  empty,
        input  ready,
        output id,
        output valid_and_ready
    );

    modport slave (
        output empty,
        output ready,
        input  id,
        input  valid_and_ready
    );
endinterface

// File: rtl/edf_queue_arbiter_deadline_tracker.sv
// Per-queue period counter, remaining-deadline register and sticky miss flag.
module edf_deadline_tracker
    import edf_pkg::*;
#(
    parameter int REGISTER_SIZE = DEFAULT_REGISTER_SIZE
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [REGISTER_SIZE-1:0] deadline,
    input  logic [REGISTER_SIZE-1:0] period,
    input  logic                     resync,
    input  logic                     empty,
    output logic [REGISTER_SIZE-1:0] remaining,
    output logic                     miss
);
    localparam logic [REGISTER_SIZE-1:0] DISABLED_VALUE = {REGISTER_SIZE{DEADLINE_DISABLED[0]}};
    localparam logic [REGISTER_SIZE-1:0] REG_ONE        = REGISTER_SIZE'(1);

    logic [REGISTER_SIZE-1:0] period_cnt_q, period_cnt_d;
    logic [REGISTER_SIZE-1:0] remaining_q, remaining_d;
    logic                     miss_q, miss_d;
    logic                     disabled;
    logic                     release_now;

    always_comb begin
        disabled     = (period == '0);
        // >= so a period shortened below the current count still wraps promptly
        release_now  = !disabled && (period_cnt_q >= period - REG_ONE);
        remaining    = disabled ? DISABLED_VALUE : remaining_q;
        miss_d       = miss_q | ((remaining == '0) && !empty);
        period_cnt_d = period_cnt_q + REG_ONE;
        remaining_d  = (remaining_q == '0) ? '0 : remaining_q - REG_ONE;
        if (resync) begin
            period_cnt_d = '0;
            remaining_d  = deadline;
        end else if (disabled) begin
            period_cnt_d = '0;
            remaining_d  = DISABLED_VALUE;
        end else if (release_now) begin
            period_cnt_d = '0;
            remaining_d  = deadline;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            period_cnt_q <= '0;
            remaining_q  <= deadline;
            miss_q       <= 1'b0;
        end else begin
            period_cnt_q <= period_cnt_d;
            remaining_q  <= remaining_d;
            miss_q       <= miss_d;
        end
    end

    assign miss = miss_q;
endmodule

// File: rtl/edf_queue_arbiter.sv
// Earliest-Deadline-First arbiter: grants the non-empty queue with the smallest remaining deadline.
// Ties go to the lowest index, or round-robin when EDF_TIE_ROUND_ROBIN_EN is defined.
module edf_queue_arbiter
    import edf_pkg::*;
#(
    parameter int NUMBER_OF_QUEUES = DEFAULT_NUMBER_OF_QUEUES,
    parameter int REGISTER_SIZE    = $bits(deadline_t)
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] deadlines,
    input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] periods,
    input  logic [REGISTER_SIZE-1:0]                      counter_reset,
    edf_queue_arbiter_if.master                           bus,
    output logic [NUMBER_OF_QUEUES-1:0]                   deadline_miss
);
    localparam int                       ID_W    = $clog2(NUMBER_OF_QUEUES);
    localparam logic [REGISTER_SIZE-1:0] REG_ONE = REGISTER_SIZE'(1);

    logic [REGISTER_SIZE-1:0] time_q, time_d;
    logic                     resync;
    logic [REGISTER_SIZE-1:0] remaining [NUMBER_OF_QUEUES];

    logic                     win_found;
    logic [ID_W-1:0]          win_id;
    logic [REGISTER_SIZE-1:0] win_rem;
    logic                     grant;
    logic                     valid_q, valid_d;
    logic [ID_W-1:0]          id_q, id_d;

    always_comb begin
        resync = (counter_reset != '0) && (time_q == counter_reset - REG_ONE);
        time_d = resync ? '0 : time_q + REG_ONE;
    end

    for (genvar i = 0; i < NUMBER_OF_QUEUES; i++) begin : g_track
        edf_deadline_tracker #(
            .REGISTER_SIZE(REGISTER_SIZE)
        ) u_track (
            .clock    (clock),
            .reset    (reset),
            .deadline (deadlines[i]),
            .period   (periods[i]),
            .resync   (resync),
            .empty    (bus.empty[i]),
            .remaining(remaining[i]),
            .miss     (deadline_miss[i])
        );
    end

`ifdef EDF_TIE_ROUND_ROBIN_EN
    logic [ID_W-1:0] last_q, last_d;
    int              scan_idx;

    // Scan starts just after the last grant; strict < keeps the first queue met on a tie.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_rem   = '1;
        scan_idx  = 0;
        for (int k = 0; k < NUMBER_OF_QUEUES; k++) begin
            scan_idx = int'(last_q) + 1 + k;
            if (scan_idx >= NUMBER_OF_QUEUES) scan_idx = scan_idx - NUMBER_OF_QUEUES;
            if (!bus.empty[scan_idx] && (!win_found || remaining[scan_idx] < win_rem)) begin
                win_found = 1'b1;
                win_id    = ID_W'(scan_idx);
                win_rem   = remaining[scan_idx];
            end
        end
        last_d = grant ? win_id : last_q;
    end

    always_ff @(posedge clock) begin
        if (reset) last_q <= ID_W'(NUMBER_OF_QUEUES - 1);
        else       last_q <= last_d;
    end
`else
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_rem   = '1;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (!bus.empty[i] && (!win_found || remaining[i] < win_rem)) begin
                win_found = 1'b1;
                win_id    = ID_W'(i);
                win_rem   = remaining[i];
            end
        end
    end
`endif

    // A pulse in flight blocks arbitration so empty can reflect the pop first.
    always_comb begin
        grant   = bus.ready && win_found && !valid_q;
        valid_d = grant;
        id_d    = grant ? win_id : id_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            time_q  <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
        end else begin
            time_q  <= time_d;
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    assign bus.valid_and_ready = valid_q;
    assign bus.id              = id_q;
endmodule
